noc_iob_bridge: RTL and testbench
=================================

NOC_IOB_BRIDGE -- requirements
Module: noc_iob_bridge

Interface
REQ-001 Parameter NOC_DATA_WIDTH, default 64: NoC flit width; SHALL be >= 64.
REQ-002 Parameter MAX_FLITS, default 4: max flits per inbound packet (header included); SHALL be >= 2.
REQ-003 Parameter OUT_DEPTH, default 16: outbound FIFO depth in flits; SHALL be a power of two and >= 4.
REQ-004 Parameter X_TILES, default 8; Y_TILES, default 8: tile mesh dimensions.
REQ-005 Parameter FBITS, default 4'b0010; MSG_TYPE_INT, default 8'd32: header fields for outbound interrupt packets.
REQ-006 Ports: clk in 1, clock; rst_n in 1, reset, asynchronous, active-low (already decided).
REQ-007 noc_in_val in 1; noc_in_rdy out 1; noc_in_data in NOC_DATA_WIDTH: inbound NoC flits.
REQ-008 req_val out 1; req_rdy in 1; req_len out 8 (payload flit count); req_flits out MAX_FLITS*NOC_DATA_WIDTH (flit 0 in LSBs): assembled inbound packet.
REQ-009 int_val in 1; int_rdy out 1; int_tileid in 32; int_data in 64: interrupt requests.
REQ-010 noc_out_val out 1; noc_out_rdy in 1; noc_out_data out NOC_DATA_WIDTH: outbound NoC flits.
REQ-011 err_clr in 1; err_in_ovf out 1; err_bad_tile out 1; out_count out $clog2(OUT_DEPTH)+1: status.

Function
REQ-012 Transfer occurs on any port pair only when val and rdy are both high at posedge clk.
REQ-013 Inbound FSM states IDLE, BODY, HOLD, DROP; noc_in_rdy = 1 in IDLE/BODY/DROP, 0 in HOLD.
REQ-014 IDLE, header accepted: store flit 0, latch len = data[29:22]; len==0 -> HOLD; len > MAX_FLITS-1 -> DROP with remaining=len; else BODY with remaining=len.
REQ-015 BODY: each accepted flit stored at next index, remaining decrements; flit accepted with remaining==1 -> HOLD next cycle.
REQ-016 DROP: flits accepted and discarded; flit accepted with remaining==1 -> IDLE and err_in_ovf set; packet never presented.
REQ-017 HOLD: req_val=1, req_len=len, req_flits stable; unused flit slots SHALL be zero; req_val&&req_rdy -> IDLE; req_val=0 in all other states.
REQ-018 Minimum inbound latency: req_val rises the cycle after the last flit is accepted.
REQ-019 Tile mapping: dest_x = int_tileid mod X_TILES, dest_y = int_tileid / X_TILES; int_tileid >= X_TILES*Y_TILES is invalid.
REQ-020 Header flit: {chipid 14'b0, dest_x 8b, dest_y 8b, FBITS, length 8'd1, MSG_TYPE_INT, 14'b0} at bits [63:0], zero above bit 63.
REQ-021 Payload flit: {int_data[63:16], 7'b0, int_data[8:0]}, zero above bit 63.
REQ-022 int_rdy = 1 only when free slots (OUT_DEPTH - out_count) >= 2, registered-state based, no combinational path from noc_out_rdy.
REQ-023 Valid accepted request pushes header then payload in a single cycle (two entries); invalid request is accepted, pushes nothing, sets err_bad_tile.
REQ-024 noc_out_val = (out_count != 0); noc_out_data = entry at read pointer; pop on noc_out_val&&noc_out_rdy.
REQ-025 Simultaneous push and pop: out_count += 1; pointers wrap modulo OUT_DEPTH.
REQ-026 Order preserved: flits leave in push order; header always immediately precedes its payload.
REQ-027 err_in_ovf, err_bad_tile sticky; err_clr clears both; same-cycle set and err_clr -> set wins.

Reset
REQ-028 rst_n low asynchronously forces: FSM IDLE, pointers/out_count 0, req_val 0, noc_out_val 0, errors 0, noc_in_rdy 1, int_rdy 1, req_len 0, req_flits 0; FIFO storage contents need not be reset.
REQ-029 Reset mid-packet discards partial inbound packet and all queued outbound flits; after deassertion, next noc_in flit is treated as a header.

Verification
REQ-030 Header len=1 then payload 0xA5 -> req_val next cycle, req_len=1, req_flits slot1=0xA5, slots 2..3 zero; req_rdy held low 5 cycles -> noc_in_rdy low throughout.
REQ-031 Header len=6 (MAX_FLITS=4) plus 6 flits -> all 7 accepted, req_val never rises, err_in_ovf=1; err_clr -> 0.
REQ-032 int_tileid=10, X_TILES=8 -> header dest_x=2, dest_y=1, length 1; payload int_data 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_01FF.
REQ-033 int_tileid=64 -> no flits emitted, err_bad_tile=1, int_rdy unaffected.
REQ-034 noc_out_rdy=0, issue 8 requests (OUT_DEPTH=16) -> out_count=16, int_rdy=0; one pop -> int_rdy stays 0; second pop -> int_rdy=1; drain order matches push order.
REQ-035 rst_n asserted mid-BODY and with out_count=6 -> outputs at reset values immediately; fresh header after release assembles correctly.

Source files
------------

// File: rtl/noc_iob_bridge.sv
// Bridge between the tile NoC and the I/O block: assembles inbound packets for
// the IOB and turns interrupt requests into outbound header+payload flit pairs.
//
// state | meaning
// IDLE  | waiting for an inbound header flit
// BODY  | collecting payload flits of an accepted packet
// HOLD  | packet complete, presented on req_* until taken
// DROP  | oversized packet, swallowing its payload flits
module noc_iob_bridge #(
  parameter int         NOC_DATA_WIDTH = 64,
  parameter int         MAX_FLITS      = 4,
  parameter int         OUT_DEPTH      = 16,
  parameter int         X_TILES        = 8,
  parameter int         Y_TILES        = 8,
  parameter logic [3:0] FBITS          = 4'b0010,
  parameter logic [7:0] MSG_TYPE_INT   = 8'd32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                noc_in_val,
  output logic                                noc_in_rdy,
  input  logic [NOC_DATA_WIDTH-1:0]           noc_in_data,
  output logic                                req_val,
  input  logic                                req_rdy,
  output logic [7:0]                          req_len,
  output logic [MAX_FLITS*NOC_DATA_WIDTH-1:0] req_flits,
  input  logic                                int_val,
  output logic                                int_rdy,
  input  logic [31:0]                         int_tileid,
  input  logic [63:0]                         int_data,
  output logic                                noc_out_val,
  input  logic                                noc_out_rdy,
  output logic [NOC_DATA_WIDTH-1:0]           noc_out_data,
  input  logic                                err_clr,
  output logic                                err_in_ovf,
  output logic                                err_bad_tile,
  output logic [$clog2(OUT_DEPTH):0]          out_count
);

  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(MAX_FLITS);
  localparam logic [7:0]       LEN_MAX     = 8'(MAX_FLITS - 1);
  localparam logic [31:0]      X_T         = 32'(X_TILES);
  localparam logic [31:0]      TILE_COUNT  = 32'(X_TILES * Y_TILES);
  localparam logic [CNT_W-1:0] PUSH2_LIMIT = CNT_W'(OUT_DEPTH - 2);

  typedef enum logic [1:0] {IDLE, BODY, HOLD, DROP} in_state_t;

  in_state_t                 state, state_nxt;
  logic                      in_fire;
  logic [7:0]                hdr_len;
  logic [7:0]                remaining;
  logic [IDX_W-1:0]          idx;
  logic [NOC_DATA_WIDTH-1:0] flit_q [MAX_FLITS];
  logic                      err_in_set;

  assign in_fire = noc_in_val && noc_in_rdy;
  assign hdr_len = noc_in_data[29:22];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_fire) begin
        if (hdr_len == 8'd0)         state_nxt = HOLD;
        else if (hdr_len > LEN_MAX)  state_nxt = DROP;
        else                         state_nxt = BODY;
      end
      BODY:    if (in_fire && remaining == 8'd1) state_nxt = HOLD;
      DROP:    if (in_fire && remaining == 8'd1) state_nxt = IDLE;
      HOLD:    if (req_val && req_rdy)           state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    noc_in_rdy = (state != HOLD);
    req_val    = (state == HOLD);
  end

  // A new header clears every slot so short packets present zeros above their payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= 8'd0;
      idx       <= '0;
      req_len   <= 8'd0;
      for (int i = 0; i < MAX_FLITS; i++) flit_q[i] <= '0;
    end else if (in_fire) begin
      case (state)
        IDLE: begin
          for (int i = 1; i < MAX_FLITS; i++) flit_q[i] <= '0;
          flit_q[0] <= noc_in_data;
          req_len   <= hdr_len;
          remaining <= hdr_len;
          idx       <= IDX_W'(1);
        end
        BODY: begin
          flit_q[idx] <= noc_in_data;
          idx         <= idx + 1'b1;
          remaining   <= remaining - 8'd1;
        end
        DROP:    remaining <= remaining - 8'd1;
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < MAX_FLITS; g++) begin : g_slot
    assign req_flits[g*NOC_DATA_WIDTH +: NOC_DATA_WIDTH] = flit_q[g];
  end

  logic                      int_fire, tile_ok, push, pop;
  logic [7:0]                dest_x, dest_y;
  logic [63:0]               hdr64, pay64;
  logic [NOC_DATA_WIDTH-1:0] mem [OUT_DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;

  assign int_rdy  = (out_count <= PUSH2_LIMIT);
  assign int_fire = int_val && int_rdy;
  assign tile_ok  = (int_tileid < TILE_COUNT);
  assign dest_x   = 8'(int_tileid % X_T);
  assign dest_y   = 8'(int_tileid / X_T);
  assign hdr64    = {14'b0, dest_x, dest_y, FBITS, 8'd1, MSG_TYPE_INT, 14'b0};
  // Payload bits [15:9] are reserved on the IOB side and always sent as zero.
  assign pay64    = int_data & 64'hFFFF_FFFF_FFFF_01FF;
  assign push     = int_fire && tile_ok;
  assign pop      = noc_out_val && noc_out_rdy;

  assign noc_out_val  = (out_count != '0);
  assign noc_out_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]        <= NOC_DATA_WIDTH'(hdr64);
      mem[wr_ptr + 1'b1] <= NOC_DATA_WIDTH'(pay64);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(2);
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   out_count <= out_count + CNT_W'(2);
        2'b11:   out_count <= out_count + CNT_W'(1);
        2'b01:   out_count <= out_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign err_in_set = (state == DROP) && in_fire && (remaining == 8'd1);

  // A fresh error event in the same cycle as err_clr survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_in_ovf   <= 1'b0;
      err_bad_tile <= 1'b0;
    end else begin
      err_in_ovf   <= err_in_set | (err_in_ovf & ~err_clr);
      err_bad_tile <= (int_fire && !tile_ok) | (err_bad_tile & ~err_clr);
    end
  end

endmodule

// File: tb/tb_noc_iob_bridge.sv
// Directed bench for noc_iob_bridge: scoreboard queues for assembled packets
// and outbound flits, checked by negedge monitors and inline assertions.
module tb_noc_iob_bridge;
  localparam int W  = 64;
  localparam int MF = 4;
  localparam int OD = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            noc_in_val, noc_in_rdy;
  logic [W-1:0]    noc_in_data;
  logic            req_val, req_rdy;
  logic [7:0]      req_len;
  logic [MF*W-1:0] req_flits;
  logic            int_val, int_rdy;
  logic [31:0]     int_tileid;
  logic [63:0]     int_data;
  logic            noc_out_val, noc_out_rdy;
  logic [W-1:0]    noc_out_data;
  logic            err_clr, err_in_ovf, err_bad_tile;
  logic [4:0]      out_count;

  always #5 clk = ~clk;

  noc_iob_bridge #(
    .NOC_DATA_WIDTH(W), .MAX_FLITS(MF), .OUT_DEPTH(OD),
    .X_TILES(8), .Y_TILES(8), .FBITS(4'b0010), .MSG_TYPE_INT(8'd32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .noc_in_val(noc_in_val), .noc_in_rdy(noc_in_rdy), .noc_in_data(noc_in_data),
    .req_val(req_val), .req_rdy(req_rdy), .req_len(req_len), .req_flits(req_flits),
    .int_val(int_val), .int_rdy(int_rdy), .int_tileid(int_tileid), .int_data(int_data),
    .noc_out_val(noc_out_val), .noc_out_rdy(noc_out_rdy), .noc_out_data(noc_out_data),
    .err_clr(err_clr), .err_in_ovf(err_in_ovf), .err_bad_tile(err_bad_tile),
    .out_count(out_count)
  );

  typedef struct {
    logic [7:0]      len;
    logic [MF*W-1:0] flits;
  } pkt_t;

  pkt_t         pkt_q[$];
  logic [W-1:0] out_q[$];
  int           total = 0;
  int           bad   = 0;

  task automatic chk(input string tag, input logic [MF*W-1:0] obs, input logic [MF*W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_hdr(input int tileid);
    logic [63:0] h;
    h = 64'd0;
    h[49:42] = 8'(tileid % 8);
    h[41:34] = 8'(tileid / 8);
    h[33:30] = 4'b0010;
    h[29:22] = 8'd1;
    h[21:14] = 8'd32;
    return h;
  endfunction

  function automatic logic [63:0] exp_pay(input logic [63:0] d);
    return {d[63:16], 7'b0, d[8:0]};
  endfunction

  task automatic send_int(input int tileid, input logic [63:0] d);
    int_val    = 1'b1;
    int_tileid = 32'(tileid);
    int_data   = d;
    out_q.push_back(exp_hdr(tileid));
    out_q.push_back(exp_pay(d));
  endtask

  task automatic drain_out(input string tag);
    noc_out_rdy = 1'b1;
    for (int i = 0; i < 64 && out_q.size() != 0; i++) step();
    chk(tag, out_q.size(), 0);
    chk({tag, "_count"}, out_count, 0);
  endtask

  // Transfers happen at the next posedge when val&&rdy is seen here.
  always @(negedge clk) begin
    if (rst_n && noc_out_val && noc_out_rdy) begin
      total++;
      assert (out_q.size() != 0) else begin
        bad++;
        $error("FAIL out_unexpected: observed flit=%0h expected none", noc_out_data);
      end
      if (out_q.size() != 0) chk("out_flit", noc_out_data, out_q.pop_front());
    end
    if (rst_n && req_val && req_rdy) begin
      total++;
      assert (pkt_q.size() != 0) else begin
        bad++;
        $error("FAIL req_unexpected: observed len=%0d expected none", req_len);
      end
      if (pkt_q.size() != 0) begin
        pkt_t p;
        p = pkt_q.pop_front();
        chk("req_len", req_len, p.len);
        chk("req_flits", req_flits, p.flits);
      end
    end
  end

  initial begin
    int   ids [8];
    pkt_t p;
    ids = '{0, 1, 7, 8, 9, 63, 62, 31};
    rst_n = 1'b0; noc_in_val = 1'b0; noc_in_data = '0; req_rdy = 1'b0;
    int_val = 1'b0; int_tileid = '0; int_data = '0; noc_out_rdy = 1'b0; err_clr = 1'b0;
    step(); step();
    chk("rst_noc_in_rdy", noc_in_rdy, 1);
    chk("rst_int_rdy", int_rdy, 1);
    chk("rst_req_val", req_val, 0);
    chk("rst_noc_out_val", noc_out_val, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_req_flits", req_flits, 0);
    chk("rst_errs", {err_in_ovf, err_bad_tile}, 0);
    rst_n = 1'b1;
    step();

    // Single-payload packet, then a slow consumer.
    noc_in_val = 1'b1; noc_in_data = 64'h0000_0000_0040_0000;
    step();
    noc_in_data = 64'hA5;
    step();
    noc_in_val = 1'b0; noc_in_data = '0;
    chk("t030_req_val_next", req_val, 1);
    p.len = 8'd1;
    p.flits = {64'd0, 64'd0, 64'hA5, 64'h0000_0000_0040_0000};
    pkt_q.push_back(p);
    repeat (5) begin
      chk("t030_in_rdy_hold", noc_in_rdy, 0);
      chk("t030_req_val_hold", req_val, 1);
      step();
    end
    req_rdy = 1'b1;
    step();
    req_rdy = 1'b0;
    chk("t030_req_val_done", req_val, 0);
    chk("t030_in_rdy_done", noc_in_rdy, 1);
    chk("t030_pkt_taken", pkt_q.size(), 0);

    // Oversized packet is swallowed and flagged.
    req_rdy = 1'b1;
    noc_in_val = 1'b1;
    for (int i = 0; i < 7; i++) begin
      noc_in_data = (i == 0) ? 64'(6) << 22 : 64'h100 + 64'(i);
      chk("t031_in_rdy", noc_in_rdy, 1);
      step();
    end
    noc_in_val = 1'b0;
    chk("t031_ovf_set", err_in_ovf, 1);
    repeat (3) begin
      chk("t031_no_req", req_val, 0);
      step();
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t031_ovf_clr", err_in_ovf, 0);
    req_rdy = 1'b0;

    // Tile 10 mapping and payload masking.
    noc_out_rdy = 1'b1;
    send_int(10, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    int_val = 1'b0;
    chk("t032_hdr", noc_out_data, 64'h0000_0804_8048_0000);
    step();
    chk("t032_pay", noc_out_data, 64'hFFFF_FFFF_FFFF_01FF);
    step();
    chk("t032_drained", out_q.size(), 0);
    chk("t032_count", out_count, 0);

    // Out-of-range tile, with err_clr in the same cycle.
    int_val = 1'b1; int_tileid = 32'd64; int_data = 64'h1234; err_clr = 1'b1;
    step();
    int_val = 1'b0; err_clr = 1'b0;
    chk("t033_bad_tile", err_bad_tile, 1);
    chk("t033_int_rdy", int_rdy, 1);
    chk("t033_count", out_count, 0);
    step();
    chk("t033_no_flit", noc_out_val, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t033_clr", err_bad_tile, 0);

    // Fill to capacity, watch int_rdy around the two-slot threshold.
    noc_out_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t034_int_rdy_fill", int_rdy, 1);
      send_int(ids[i], {$urandom, $urandom});
      step();
    end
    int_val = 1'b0;
    chk("t034_full_count", out_count, 16);
    chk("t034_full_int_rdy", int_rdy, 0);
    noc_out_rdy = 1'b1;
    step();
    noc_out_rdy = 1'b0;
    chk("t034_pop1_count", out_count, 15);
    chk("t034_pop1_int_rdy", int_rdy, 0);
    noc_out_rdy = 1'b1;
    step();
    noc_out_rdy = 1'b0;
    chk("t034_pop2_count", out_count, 14);
    chk("t034_pop2_int_rdy", int_rdy, 1);
    noc_out_rdy = 1'b1;
    send_int(5, {$urandom, $urandom});
    step();
    int_val = 1'b0;
    chk("t034_push_pop_count", out_count, 15);
    drain_out("t034_drain");

    // Reset in the middle of a packet with flits queued.
    noc_out_rdy = 1'b0;
    for (int i = 3; i < 6; i++) begin
      send_int(i, {$urandom, $urandom});
      step();
    end
    int_val = 1'b0;
    chk("t035_pre_count", out_count, 6);
    noc_in_val = 1'b1; noc_in_data = 64'(3) << 22;
    step();
    noc_in_data = 64'h111;
    step();
    noc_in_val = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t035_req_val", req_val, 0);
    chk("t035_out_val", noc_out_val, 0);
    chk("t035_count", out_count, 0);
    chk("t035_in_rdy", noc_in_rdy, 1);
    chk("t035_int_rdy", int_rdy, 1);
    chk("t035_req_len", req_len, 0);
    chk("t035_req_flits", req_flits, 0);
    out_q.delete();
    step(); step();
    #2;
    rst_n = 1'b1;
    step();
    noc_in_val = 1'b1; noc_in_data = 64'(2) << 22;
    step();
    noc_in_data = 64'h222;
    step();
    noc_in_data = 64'h333;
    step();
    noc_in_val = 1'b0;
    chk("t035_req_val_after", req_val, 1);
    p.len = 8'd2;
    p.flits = {64'd0, 64'h333, 64'h222, 64'(2) << 22};
    pkt_q.push_back(p);
    req_rdy = 1'b1;
    step();
    req_rdy = 1'b0;
    chk("t035_pkt_taken", pkt_q.size(), 0);
    chk("t035_no_stale_out", noc_out_val, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
